// File: rtl/if_id_stage.sv
// if_id_stage
//   Register stage between instruction fetch and decode. A two-entry skid
//   buffer holds {instr, pc, pc+4} in FIFO order. Decode can stall without
//   fetch losing an instruction. A taken branch or jump (flush) discards
//   every buffered entry and the instruction offered in the same cycle.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   reset      : synchronous, active-low
//   in_valid   : fetch offers instr_in / pc_in / pc_4_in
//   in_ready   : stage accepts an entry this cycle (registered state only)
//   instr_in   : fetched instruction
//   pc_in      : PC of the fetched instruction
//   pc_4_in    : PC+4 from the fetch adder
//   flush      : drop all contents and this cycle's input
//   out_valid  : head entry valid for decode
//   out_ready  : decode takes the head entry this cycle
//   instr_out  : head instruction (NOP when empty)
//   pc_out     : head PC (0 when empty)
//   pc_4_out   : head PC+4 (0 when empty)
//   opcode     : instr_out[6:0]
//   fetch_hold : !in_ready; fetch freezes its PC while this is high
//   stall_cnt  : saturating count of cycles fetch was back-pressured
module if_id_stage #(
  parameter int          n     = 32,
  parameter int          CNT_W = 16,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [n-1:0]     instr_in,
  input  logic [n-1:0]     pc_in,
  input  logic [n-1:0]     pc_4_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [n-1:0]     instr_out,
  output logic [n-1:0]     pc_out,
  output logic [n-1:0]     pc_4_out,
  output logic [6:0]       opcode,
  output logic             fetch_hold,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [n-1:0] NOP_N = n'(NOP);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             enq, deq;

  // Data slots carry no reset: occupancy alone decides what is visible.
  logic [n-1:0] instr_p1 [2];
  logic [n-1:0] pc_p1    [2];
  logic [n-1:0] pc4_p1   [2];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Handshake decode. in_ready depends only on registered occupancy, so
  // there is no combinational path from out_ready back to fetch.
  assign in_ready   = (state_q != FULL);
  assign out_valid  = (state_q != EMPTY);
  assign fetch_hold = ~in_ready;
  assign enq        = in_valid && in_ready && !flush;
  assign deq        = out_valid && out_ready && !flush;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    stall_d  = stall_q;

    if (in_valid && !in_ready && !flush)
      stall_d = sat_inc(stall_q);

    if (flush) begin
      state_d  = EMPTY;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (enq) wr_ptr_d = ~wr_ptr_q;
      if (deq) rd_ptr_d = ~rd_ptr_q;
      unique case (state_q)
        EMPTY:   if (enq) state_d = ONE;
        ONE:     if (enq && !deq) state_d = FULL;
                 else if (deq && !enq) state_d = EMPTY;
        FULL:    if (deq) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      stall_q  <= stall_d;
    end
  end

  // Stage p1: capture the fetched entry into the write slot.
  always_ff @(posedge clk) begin
    if (reset && enq) begin
      instr_p1[wr_ptr_q] <= instr_in;
      pc_p1[wr_ptr_q]    <= pc_in;
      pc4_p1[wr_ptr_q]   <= pc_4_in;
    end
  end

  // Decode-facing outputs: the head slot, or NOP/0/0 when empty.
  assign instr_out = out_valid ? instr_p1[rd_ptr_q] : NOP_N;
  assign pc_out    = out_valid ? pc_p1[rd_ptr_q]    : '0;
  assign pc_4_out  = out_valid ? pc4_p1[rd_ptr_q]   : '0;
  assign opcode    = instr_out[6:0];
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;
  localparam int N  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b1;
  logic          in_ready;
  logic [N-1:0]  instr_in = 32'h00500093;
  logic [N-1:0]  pc_in = '0;
  logic [N-1:0]  pc_4_in = 32'd4;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [N-1:0]  instr_out, pc_out, pc_4_out;
  logic [6:0]    opcode;
  logic          fetch_hold;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  if_id_stage #(.n(N), .CNT_W(CW), .NOP(32'h00000013)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr_in(instr_in), .pc_in(pc_in), .pc_4_in(pc_4_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .instr_out(instr_out),
    .pc_out(pc_out), .pc_4_out(pc_4_out), .opcode(opcode),
    .fetch_hold(fetch_hold), .stall_cnt(stall_cnt)
  );

  // Reference: a bounded FIFO of at most two accepted entries.
  typedef struct packed {
    logic [N-1:0] instr;
    logic [N-1:0] pc;
    logic [N-1:0] pc4;
  } ent_t;

  ent_t          exp_q[$];
  int            size_pre = 0;
  int            n_chk = 0;
  int            n_fail = 0;
  int            max_occ = 0;
  logic [CW-1:0] stall_m = '0;
  bit            mon_on = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: checks DUT outputs against the model, pops on handshake.
  initial begin
    forever begin
      @(negedge clk);
      size_pre = exp_q.size();
      if (size_pre > max_occ) max_occ = size_pre;
      if (mon_on) begin
        chk("out_valid", 64'(out_valid), 64'(size_pre != 0));
        chk("in_ready", 64'(in_ready), 64'(size_pre < 2));
        chk("fetch_hold", 64'(fetch_hold), 64'(size_pre == 2));
        chk("stall_cnt", 64'(stall_cnt), 64'(stall_m));
        if (size_pre != 0) begin
          chk("instr_out", 64'(instr_out), 64'(exp_q[0].instr));
          chk("pc_out", 64'(pc_out), 64'(exp_q[0].pc));
          chk("pc_4_out", 64'(pc_4_out), 64'(exp_q[0].pc4));
          chk("opcode", 64'(opcode), 64'(exp_q[0].instr[6:0]));
        end else begin
          chk("instr_nop", 64'(instr_out), 64'h13);
          chk("pc_zero", 64'(pc_out), 64'h0);
          chk("pc4_zero", 64'(pc_4_out), 64'h0);
          chk("opcode_nop", 64'(opcode), 64'h13);
        end
      end
      if (!reset) begin
        exp_q.delete();
        stall_m = '0;
        mon_on = 1;
      end else if (flush) begin
        exp_q.delete();
      end else begin
        if (in_valid && size_pre == 2 && stall_m != {CW{1'b1}})
          stall_m = stall_m + 1'b1;
        if (size_pre != 0 && out_ready)
          void'(exp_q.pop_front());
      end
    end
  end

  // Driver: one cycle of stimulus; accepted entries go to the scoreboard.
  task automatic step(input logic r, input logic v, input logic [N-1:0] ins,
                      input logic [N-1:0] pc, input logic fl, input logic ordy);
    @(posedge clk);
    #1;
    reset     = r;
    in_valid  = v;
    instr_in  = ins;
    pc_in     = pc;
    pc_4_in   = pc + 32'd4;
    flush     = fl;
    out_ready = ordy;
    @(negedge clk);
    #1;
    if (r && !fl && v && size_pre < 2)
      exp_q.push_back('{instr: ins, pc: pc, pc4: pc + 32'd4});
  endtask

  task automatic idle(input int cycles, input logic ordy);
    for (int i = 0; i < cycles; i++) step(1'b1, 1'b0, $urandom, '0, 1'b0, ordy);
  endtask

  initial begin
    logic [N-1:0] ins;
    // Reset held with a valid input present.
    step(1'b0, 1'b1, 32'h00500093, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h00500093, 32'h0, 1'b0, 1'b0);
    idle(1, 1'b0);

    // Streaming with decode always ready.
    max_occ = 0;
    step(1'b1, 1'b1, 32'h00100093, 32'h0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 32'h00200113, 32'h4, 1'b0, 1'b1);
    step(1'b1, 1'b1, 32'h00300193, 32'h8, 1'b0, 1'b1);
    idle(2, 1'b1);
    chk("stream_max_occupancy", 64'(max_occ), 64'd1);

    // Back-pressure: third entry held by fetch until accepted.
    step(1'b1, 1'b1, 32'h01000213, 32'h10, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h01400293, 32'h14, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'h01800313, 32'h18, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h01800313, 32'h18, 1'b0, 1'b1);
    step(1'b1, 1'b1, 32'h01800313, 32'h18, 1'b0, 1'b1);
    idle(4, 1'b1);

    // Flush while full, with a valid input in the same cycle.
    step(1'b1, 1'b1, 32'h02000393, 32'h20, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h02400413, 32'h24, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h02800493, 32'h28, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Simultaneous enqueue and dequeue with one entry held.
    step(1'b1, 1'b1, 32'h03000513, 32'h30, 1'b0, 1'b0);
    max_occ = 0;
    step(1'b1, 1'b1, 32'h03400593, 32'h34, 1'b0, 1'b1);
    idle(1, 1'b0);
    chk("enq_deq_occupancy", 64'(max_occ), 64'd1);
    idle(2, 1'b1);

    // Saturation of the stall counter, then reset mid-stall.
    step(1'b1, 1'b1, 32'h04000613, 32'h40, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h04400693, 32'h44, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 32'h04800713, 32'h48, 1'b0, 1'b0);
    chk("stall_saturated", 64'(stall_m), 64'd15);
    step(1'b0, 1'b1, 32'h04800713, 32'h48, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      ins = $urandom;
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0), ins,
           {$urandom_range(0, 1023), 2'b00}, ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 4) < 3));
    end
    idle(4, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Pipeline stage directly downstream of instruction fetch. Captures instr, pc and pc+4 from fetch and presents them to decode.
- Contains a 2-entry skid buffer with valid/ready handshakes on both sides.
- Taken branch/jump flush discards wrong-path instructions.
- Drives a hold signal back to fetch so the PC register can freeze while decode stalls.

Parameters:
n, 32, data/address width of instr, pc, pc_4.
CNT_W, 16, width of the saturating stall counter.
NOP, 32'h00000013, instruction presented when stage is empty or flushed (addi x0,x0,0); low n bits used.

Ports:
clk  in  1  single clock, all state updates on rising edge
reset  in  1  synchronous, active-low; sampled on rising edge of clk
in_valid  in  1  fetch presents a valid instruction
in_ready  out  1  stage can accept an entry this cycle
instr_in  in  n  fetched instruction
pc_in  in  n  PC of fetched instruction
pc_4_in  in  n  PC+4 from fetch adder
flush  in  1  taken branch/jump resolved; discard all contents and this cycle's input
out_valid  out  1  head entry valid for decode
out_ready  in  1  decode accepts head entry this cycle
instr_out  out  n  head instruction (NOP when empty)
pc_out  out  n  head PC (0 when empty)
pc_4_out  out  n  head PC+4 (0 when empty)
opcode  out  7  instr_out[6:0]
fetch_hold  out  1  equals !in_ready; upstream PC enable is its inverse
stall_cnt  out  CNT_W  saturating count of back-pressured cycles

Behaviour:
- State: occupancy count with states EMPTY(0), ONE(1), FULL(2). Two storage slots, circular read/write pointers, FIFO order.
- Reset (reset==0 at posedge):
  - count=0, pointers=0, stall_cnt=0.
  - Outputs after reset: out_valid=0, instr_out=NOP, pc_out=0, pc_4_out=0, in_ready=1, fetch_hold=0.
  - Inputs are ignored while reset is low.
  - Reset overrides flush and any handshake. Reset mid-operation drops all contents.
- in_ready is a function of registered state only: in_ready = (count != 2). It has no combinational path from out_ready.
- Enqueue condition: in_valid && in_ready && !flush.
- Dequeue condition: out_valid && out_ready && !flush.
- out_valid = (count != 0). Head fields are driven from the read slot. When count==0, fields are forced to NOP/0/0.
- Latency: an entry enqueued at edge k is visible on the outputs after edge k (1 cycle). There is no combinational input-to-output data path.
- Transitions (no flush):
  - EMPTY + enq -> ONE.
  - ONE + enq + deq -> ONE; the new entry becomes head.
  - ONE + enq only -> FULL.
  - ONE + deq only -> EMPTY.
  - FULL + deq -> ONE.
  - FULL + in_valid -> no enqueue. The input is not consumed and fetch must hold it.
  - Neither enq nor deq -> no change.
- Flush (flush==1 at posedge, reset high):
  - count -> 0, pointers -> 0.
  - The input that cycle is discarded and nothing is dequeued.
  - Next cycle: out_valid=0, instr_out=NOP, in_ready=1.
  - Flush while FULL or ONE behaves identically.
- Output stability: while out_valid && !out_ready and no flush, the outputs hold their values.
- stall_cnt: increments by 1 on each edge where in_valid && !in_ready && !flush && reset. It saturates at 2^CNT_W-1 and never wraps.
- opcode always equals instr_out[6:0], including NOP (7'h13) when empty.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1, instr_in=32'h00500093 -> after release: out_valid=0, instr_out=32'h00000013, pc_out=0, in_ready=1, stall_cnt=0.
- Streaming: out_ready=1, feed pc=0,4,8 with instr A,B,C on consecutive cycles -> out_valid=1 one cycle after each input; pc_out sequence 0,4,8; pc_4_out 4,8,12; count never exceeds 1.
- Back-pressure: out_ready=0, feed pc=0x10,0x14,0x18 -> first two accepted; in_ready=0 and fetch_hold=1 after 2nd; 0x18 held with stall_cnt incrementing 1 per cycle. Raise out_ready -> outputs 0x10,0x14,0x18 in order with no loss or duplication.
- Flush when FULL: fill with pc 0x20,0x24, assert flush with in_valid=1, pc_in=0x28 -> next cycle out_valid=0, instr_out=NOP, in_ready=1; 0x28 never appears on outputs.
- Simultaneous enq/deq in ONE: head pc=0x30, out_ready=1, in_valid=1 with pc_in=0x34 -> next cycle pc_out=0x34, count stays 1.
- Saturation: CNT_W=4, hold FULL with in_valid=1 for 20 cycles -> stall_cnt stops at 15. Reset mid-stall -> stall_cnt=0 and out_valid=0 next cycle.
